// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - three-bit dice roller driven by an 8-bit LFSR
//
// Purpose: on a rising edge of roll, tumbles the dice for ROLL_CYCLES clocks,
// then holds a settled d1/d2/d3 triple for the downstream evaluator.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   roll       in   roll request level; only its rising edge acts
//   d1,d2,d3   out  dice bits (registered)
//   busy       out  high while tumbling
//   valid      out  high while d1..d3 hold a settled result
//   roll_count out  completed rolls, saturating at 8'hFF

module dice_roller #(
    parameter int          ROLL_CYCLES = 16,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       busy,
    output logic       valid,
    output logic [7:0] roll_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROLL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Counter reload: the entry edge plus ROLL_CYCLES-1 decrements plus the
    // latching clock puts valid exactly ROLL_CYCLES clocks after the entry edge.
    localparam logic [7:0] CNT_LOAD = 8'(ROLL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       roll_q, roll_d;
    logic [2:0] dice_q, dice_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic [7:0] roll_count_q, roll_count_d;

    logic       lfsr_fb;
    logic       roll_edge;
    logic [2:0] lfsr_dice;

    // x^8+x^6+x^5+x^4+1 in shift-left form: taps at bits 7,5,4,3.
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign roll_edge = roll & ~roll_q;
    assign lfsr_dice = {lfsr_q[0], lfsr_q[3], lfsr_q[6]};

    always_comb begin
        // All-zero is the only lock-up state; reseed if it is ever reached.
        if (lfsr_q == 8'h00) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
        roll_d = roll;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dice_d       = dice_q;
        busy_d       = busy_q;
        valid_d      = valid_q;
        roll_count_d = roll_count_q;

        case (state_q)
            S_IDLE: begin
                dice_d  = 3'b000;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (roll_edge) begin
                    state_d = S_ROLL;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_ROLL: begin
                // Edges are deliberately not examined here: no restart mid-tumble.
                dice_d = lfsr_dice;
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    if (roll_count_q != 8'hFF) begin
                        roll_count_d = roll_count_q + 8'd1;
                    end
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                if (roll_edge) begin
                    state_d = S_ROLL;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                dice_d  = 3'b000;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            cnt_q        <= 8'd0;
            // Treat roll as already high so a level held through reset
            // release does not count as a new press.
            roll_q       <= 1'b1;
            dice_q       <= 3'b000;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            roll_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            roll_q       <= roll_d;
            dice_q       <= dice_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            roll_count_q <= roll_count_d;
        end
    end

    assign d1         = dice_q[2];
    assign d2         = dice_q[1];
    assign d3         = dice_q[0];
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign roll_count = roll_count_q;

endmodule
